// File: rtl/rs_alu_pool_if.sv
// Handshake bundle between allocator, CDB, ALU and the ALU reservation station.
// The station connects through the slave modport; the driving environment uses master.
interface rs_alu_pool_if #(
  parameter int DEPTH   = 4,
  parameter int CDB_CNT = 3,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int OP_W    = 6,
  parameter int RA_W    = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [XLEN-1:0]           alloc_pc;
  logic [OP_W-1:0]           alloc_op;
  logic [TAG_W-1:0]          alloc_tagx;
  logic [TAG_W-1:0]          alloc_tagy;
  logic [XLEN-1:0]           alloc_datax;
  logic [XLEN-1:0]           alloc_datay;
  logic [TAG_W-1:0]          alloc_tagw;
  logic [RA_W-1:0]           alloc_rd;
  logic [CDB_CNT-1:0]        cdb_valid;
  logic [CDB_CNT*TAG_W-1:0]  cdb_tag;
  logic [CDB_CNT*XLEN-1:0]   cdb_data;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [XLEN-1:0]           issue_pc;
  logic [OP_W-1:0]           issue_op;
  logic [XLEN-1:0]           issue_datax;
  logic [XLEN-1:0]           issue_datay;
  logic [TAG_W-1:0]          issue_tagw;
  logic [RA_W-1:0]           issue_rd;
  logic [CNT_W-1:0]          count;

  modport master (
    output flush, alloc_valid, alloc_pc, alloc_op, alloc_tagx, alloc_tagy,
           alloc_datax, alloc_datay, alloc_tagw, alloc_rd,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  alloc_ready, issue_valid, issue_pc, issue_op, issue_datax,
           issue_datay, issue_tagw, issue_rd, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_pc, alloc_op, alloc_tagx, alloc_tagy,
           alloc_datax, alloc_datay, alloc_tagw, alloc_rd,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output alloc_ready, issue_valid, issue_pc, issue_op, issue_datax,
           issue_datay, issue_tagw, issue_rd, count
  );
endinterface

// File: rtl/rs_alu_pool.sv
// ALU reservation station: collapsing age-ordered queue with CDB operand capture
// and oldest-ready-first issue to a single ALU.
module rs_alu_pool #(
  parameter int DEPTH   = 4,
  parameter int CDB_CNT = 3,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int OP_W    = 6,
  parameter int RA_W    = 5
) (
  input  logic          clk,
  input  logic          rst,
  rs_alu_pool_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tagx;
    logic [XLEN-1:0]   datax;
    logic [TAG_W-1:0]  tagy;
    logic [XLEN-1:0]   datay;
    logic [TAG_W-1:0]  tagw;
    logic [RA_W-1:0]   rd;
  } entry_t;

  entry_t            ent_reg  [DEPTH];
  entry_t            ent_next [DEPTH];
  entry_t            ent_w    [DEPTH+1];
  entry_t            alloc_raw;
  entry_t            alloc_ent;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  alloc_slot;
  logic [TAG_W-1:0]  cdb_tag_u  [CDB_CNT];
  logic [XLEN-1:0]   cdb_data_u [CDB_CNT];
  logic [CDB_CNT-1:0] cdb_valid;
  logic [DEPTH-1:0]  ready;
  logic [IDX_W-1:0]  sel_idx;
  logic              issue_fire;
  logic              alloc_fire;

  assign cdb_valid = bus.cdb_valid;

  genvar gi;
  generate
    for (gi = 0; gi < CDB_CNT; gi++) begin : g_cdb
      assign cdb_tag_u[gi]  = bus.cdb_tag[gi*TAG_W +: TAG_W];
      assign cdb_data_u[gi] = bus.cdb_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Scanning from the highest bus down lets the lowest matching bus win.
  function automatic entry_t wake_entry(input entry_t e);
    entry_t r;
    r = e;
    for (int k = CDB_CNT - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (e.tagx != '0) && (cdb_tag_u[k] == e.tagx)) begin
        r.tagx  = '0;
        r.datax = cdb_data_u[k];
      end
      if (cdb_valid[k] && (e.tagy != '0) && (cdb_tag_u[k] == e.tagy)) begin
        r.tagy  = '0;
        r.datay = cdb_data_u[k];
      end
    end
    return r;
  endfunction

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign ent_w[gi] = wake_entry(ent_reg[gi]);
      assign ready[gi] = ent_reg[gi].valid && (ent_reg[gi].tagx == '0) &&
                         (ent_reg[gi].tagy == '0);
    end
  endgenerate
  // Sentinel so the top slot shifts in an empty entry on issue.
  assign ent_w[DEPTH] = '0;

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    alloc_raw       = '0;
    alloc_raw.valid = 1'b1;
    alloc_raw.pc    = bus.alloc_pc;
    alloc_raw.op    = bus.alloc_op;
    alloc_raw.tagx  = bus.alloc_tagx;
    alloc_raw.datax = bus.alloc_datax;
    alloc_raw.tagy  = bus.alloc_tagy;
    alloc_raw.datay = bus.alloc_datay;
    alloc_raw.tagw  = bus.alloc_tagw;
    alloc_raw.rd    = bus.alloc_rd;
  end
  assign alloc_ent = wake_entry(alloc_raw);

  assign bus.alloc_ready = (count_reg < CNT_W'(DEPTH));
  assign bus.issue_valid = |ready;
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign alloc_slot      = count_reg - CNT_W'(issue_fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_next[i] = ent_w[i];
      if (issue_fire && (IDX_W'(i) >= sel_idx)) ent_next[i] = ent_w[i+1];
      if (alloc_fire && (CNT_W'(i) == alloc_slot)) ent_next[i] = alloc_ent;
      if (bus.flush) ent_next[i].valid = 1'b0;
    end
    if (bus.flush) count_next = '0;
    else           count_next = count_reg + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) ent_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) ent_reg[i] <= ent_next[i];
    end
  end

  assign bus.issue_pc    = ent_reg[sel_idx].pc;
  assign bus.issue_op    = ent_reg[sel_idx].op;
  assign bus.issue_datax = ent_reg[sel_idx].datax;
  assign bus.issue_datay = ent_reg[sel_idx].datay;
  assign bus.issue_tagw  = ent_reg[sel_idx].tagw;
  assign bus.issue_rd    = ent_reg[sel_idx].rd;
  assign bus.count       = count_reg;
endmodule

// File: tb/tb_rs_alu_pool.sv
// Bench for rs_alu_pool: directed scenarios plus a randomized run, all checked
// against an age-ordered queue model of the station.
module tb_rs_alu_pool;
  localparam int DEPTH = 4, CDB_CNT = 3, TAG_W = 4, XLEN = 32, OP_W = 6, RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_alu_pool_if #(.DEPTH(DEPTH), .CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .XLEN(XLEN),
                   .OP_W(OP_W), .RA_W(RA_W)) bus ();
  rs_alu_pool #(.DEPTH(DEPTH), .CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .XLEN(XLEN),
                .OP_W(OP_W), .RA_W(RA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tx;
    logic [XLEN-1:0]  dx;
    logic [TAG_W-1:0] ty;
    logic [XLEN-1:0]  dy;
    logic [TAG_W-1:0] tw;
    logic [RA_W-1:0]  rd;
  } op_t;

  op_t mq[$];
  int  errors = 0;
  int  checks = 0;

  function automatic void wake_src(inout logic [TAG_W-1:0] t, inout logic [XLEN-1:0] d);
    for (int k = 0; k < CDB_CNT; k++) begin
      if (t != 0 && bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == t) begin
        d = bus.cdb_data[k*XLEN +: XLEN];
        t = 0;
      end
    end
  endfunction

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].tx == 0 && mq[i].ty == 0) return i;
    return -1;
  endfunction

  // Advance model and DUT by one edge using the inputs currently driven.
  task automatic cycle();
    int  s;
    bit  fi, fa;
    op_t n, e;
    if (rst || bus.flush) begin
      mq.delete();
    end else begin
      s  = model_sel();
      fi = bus.issue_ready && (s >= 0);
      fa = bus.alloc_valid && (mq.size() < DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        wake_src(e.tx, e.dx);
        wake_src(e.ty, e.dy);
        mq[i] = e;
      end
      if (fi) begin
        $display("issue pc=%h datax=%h datay=%h", mq[s].pc, mq[s].dx, mq[s].dy);
        mq.delete(s);
      end
      if (fa) begin
        n.pc = bus.alloc_pc;     n.op = bus.alloc_op;
        n.tx = bus.alloc_tagx;   n.dx = bus.alloc_datax;
        n.ty = bus.alloc_tagy;   n.dy = bus.alloc_datay;
        n.tw = bus.alloc_tagw;   n.rd = bus.alloc_rd;
        wake_src(n.tx, n.dx);
        wake_src(n.ty, n.dy);
        $display("alloc pc=%h tagx=%0d tagy=%0d", n.pc, bus.alloc_tagx, bus.alloc_tagy);
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0;       bus.alloc_valid = 0;  bus.alloc_pc = 0;   bus.alloc_op = 0;
    bus.alloc_tagx = 0;  bus.alloc_tagy = 0;   bus.alloc_datax = 0; bus.alloc_datay = 0;
    bus.alloc_tagw = 0;  bus.alloc_rd = 0;     bus.cdb_valid = 0;  bus.cdb_tag = 0;
    bus.cdb_data = 0;    bus.issue_ready = 0;
  endtask

  task automatic drive_alloc(input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] tx,
                             input logic [XLEN-1:0] dx, input logic [TAG_W-1:0] ty,
                             input logic [XLEN-1:0] dy);
    bus.alloc_valid = 1;  bus.alloc_pc = pc;   bus.alloc_op = pc[OP_W-1:0];
    bus.alloc_tagx = tx;  bus.alloc_datax = dx; bus.alloc_tagy = ty; bus.alloc_datay = dy;
    bus.alloc_tagw = 4'hF; bus.alloc_rd = 5'd1;
  endtask

  task automatic set_cdb(input int k, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    bus.cdb_valid[k] = 1'b1;
    bus.cdb_tag[k*TAG_W +: TAG_W] = tag;
    bus.cdb_data[k*XLEN +: XLEN]  = data;
  endtask

  task automatic clear_cdb();
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%b exp=1", bus.alloc_ready); end
    rst = 0;
  endtask

  task automatic test_alloc_ready_op();
    drive_alloc(32'h100, 0, 32'd5, 0, 32'd7);
    cycle();
    bus.alloc_valid = 0;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL ready_op_valid got=%b exp=1", bus.issue_valid); end
    checks++; if (bus.issue_datax !== 32'd5) begin errors++; $display("FAIL ready_op_datax got=%h exp=5", bus.issue_datax); end
    checks++; if (bus.issue_datay !== 32'd7) begin errors++; $display("FAIL ready_op_datay got=%h exp=7", bus.issue_datay); end
    checks++; if (bus.issue_pc !== 32'h100) begin errors++; $display("FAIL ready_op_pc got=%h exp=100", bus.issue_pc); end
    bus.issue_ready = 1;
    cycle();
    bus.issue_ready = 0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL ready_op_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_wakeup();
    drive_alloc(32'h200, 4'd3, 32'h0, 0, 32'd9);
    cycle();
    bus.alloc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_hold%0d got=%b exp=0", i, bus.issue_valid); end
      cycle();
    end
    set_cdb(1, 4'd3, 32'hDEAD);
    cycle();
    clear_cdb();
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL wakeup_valid got=%b exp=1", bus.issue_valid); end
    checks++; if (bus.issue_datax !== 32'hDEAD) begin errors++; $display("FAIL wakeup_datax got=%h exp=dead", bus.issue_datax); end
    bus.issue_ready = 1;
    cycle();
    bus.issue_ready = 0;
  endtask

  task automatic test_bypass_multi();
    drive_alloc(32'h300, 4'd5, 32'h0, 0, 32'd1);
    set_cdb(0, 4'd5, 32'h11);
    set_cdb(2, 4'd5, 32'h22);
    cycle();
    bus.alloc_valid = 0;
    clear_cdb();
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", bus.issue_valid); end
    checks++; if (bus.issue_datax !== 32'h11) begin errors++; $display("FAIL bypass_datax got=%h exp=11", bus.issue_datax); end
    bus.issue_ready = 1;
    cycle();
    bus.issue_ready = 0;
  endtask

  task automatic test_age_order();
    drive_alloc(32'hA00, 4'd6, 0, 0, 0); cycle();
    drive_alloc(32'hB00, 4'd7, 0, 0, 0); cycle();
    drive_alloc(32'hC00, 4'd8, 0, 0, 0); cycle();
    drive_alloc(32'hD00, 4'd9, 0, 0, 0); cycle();
    bus.alloc_valid = 0;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL age_fill_count got=%0d exp=4", bus.count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL age_all_wait got=%b exp=0", bus.issue_valid); end
    set_cdb(0, 4'd8, 32'hC0); cycle(); clear_cdb();
    checks++; if (bus.issue_pc !== 32'hC00) begin errors++; $display("FAIL age_c_first got=%h exp=c00", bus.issue_pc); end
    set_cdb(0, 4'd6, 32'hA0); cycle(); clear_cdb();
    checks++; if (bus.issue_pc !== 32'hA00) begin errors++; $display("FAIL age_a_oldest got=%h exp=a00", bus.issue_pc); end
    bus.issue_ready = 1;
    cycle();
    checks++; if (bus.issue_pc !== 32'hC00) begin errors++; $display("FAIL age_c_second got=%h exp=c00", bus.issue_pc); end
    cycle();
    bus.issue_ready = 0;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL age_collapse_count got=%0d exp=2", bus.count); end
    set_cdb(0, 4'd9, 32'hD0);
    set_cdb(1, 4'd7, 32'hB0);
    cycle(); clear_cdb();
    checks++; if (bus.issue_pc !== 32'hB00) begin errors++; $display("FAIL age_slot0_b got=%h exp=b00", bus.issue_pc); end
    bus.issue_ready = 1;
    cycle();
    checks++; if (bus.issue_pc !== 32'hD00) begin errors++; $display("FAIL age_slot1_d got=%h exp=d00", bus.issue_pc); end
    cycle();
    bus.issue_ready = 0;
  endtask

  task automatic test_full();
    drive_alloc(32'h410, 4'd10, 0, 0, 0); cycle();
    drive_alloc(32'h420, 4'd11, 0, 0, 0); cycle();
    drive_alloc(32'h430, 4'd12, 0, 0, 0); cycle();
    drive_alloc(32'h440, 0, 32'h44, 0, 0); cycle();
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got=%b exp=0", bus.alloc_ready); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", bus.count); end
    drive_alloc(32'h500, 0, 32'h55, 0, 0);
    bus.issue_ready = 1;
    cycle();
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got=%b exp=1", bus.alloc_ready); end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_after_issue got=%0d exp=3", bus.count); end
    bus.issue_ready = 0;
    cycle();
    bus.alloc_valid = 0;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_held_accept got=%0d exp=4", bus.count); end
    checks++; if (bus.issue_pc !== 32'h500) begin errors++; $display("FAIL full_held_pc got=%h exp=500", bus.issue_pc); end
    bus.issue_ready = 1;
    cycle();
    bus.issue_ready = 0;
  endtask

  task automatic test_flush_reset();
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count); end
    drive_alloc(32'h600, 0, 0, 0, 0);
    bus.flush = 1;
    cycle();
    bus.flush = 0;
    bus.alloc_valid = 0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid got=%b exp=0", bus.issue_valid); end
    drive_alloc(32'h700, 0, 0, 0, 0); cycle();
    checks++; if (bus.count !== 3'd1 || bus.issue_pc !== 32'h700) begin errors++; $display("FAIL flush_next_slot0 count=%0d pc=%h exp 1/700", bus.count, bus.issue_pc); end
    drive_alloc(32'h710, 4'd13, 0, 0, 0); cycle();
    drive_alloc(32'h720, 4'd14, 0, 0, 0); cycle();
    drive_alloc(32'h730, 0, 0, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
    bus.alloc_valid = 0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_alloc_ready got=%b exp=1", bus.alloc_ready); end
    drive_alloc(32'h800, 0, 0, 0, 0); cycle();
    bus.alloc_valid = 0;
    checks++; if (bus.count !== 3'd1 || bus.issue_pc !== 32'h800) begin errors++; $display("FAIL rst_next_slot0 count=%0d pc=%h exp 1/800", bus.count, bus.issue_pc); end
    bus.issue_ready = 1;
    cycle();
    bus.issue_ready = 0;
  endtask

  task automatic test_back_to_back();
    bus.issue_ready = 1;
    for (int i = 0; i < 6; i++) begin
      drive_alloc(32'h900 + i, 0, i, 0, 0);
      cycle();
      checks++; if (bus.count !== 3'd1 || bus.issue_pc !== 32'h900 + i) begin errors++; $display("FAIL b2b_%0d count=%0d pc=%h exp 1/%h", i, bus.count, bus.issue_pc, 32'h900 + i); end
    end
    bus.alloc_valid = 0;
    cycle();
    bus.issue_ready = 0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 400; n++) begin
      bus.alloc_valid = ($urandom_range(0, 1) == 1);
      bus.alloc_pc    = $urandom;
      bus.alloc_op    = OP_W'($urandom);
      bus.alloc_tagx  = ($urandom_range(0, 1) == 1) ? 4'd0 : TAG_W'($urandom_range(1, 15));
      bus.alloc_tagy  = ($urandom_range(0, 2) != 0) ? 4'd0 : TAG_W'($urandom_range(1, 15));
      bus.alloc_datax = $urandom;
      bus.alloc_datay = $urandom;
      bus.alloc_tagw  = TAG_W'($urandom);
      bus.alloc_rd    = RA_W'($urandom);
      for (int k = 0; k < CDB_CNT; k++) begin
        bus.cdb_valid[k] = ($urandom_range(0, 2) != 0);
        bus.cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        bus.cdb_data[k*XLEN +: XLEN]  = $urandom;
      end
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      bus.flush       = ($urandom_range(0, 39) == 0);
      s = model_sel();
      checks++; if (bus.count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, bus.count, mq.size()); end
      checks++; if (bus.alloc_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_alloc_ready cyc=%0d got=%b", n, bus.alloc_ready); end
      checks++; if (bus.issue_valid !== (s >= 0)) begin errors++; $display("FAIL rnd_issue_valid cyc=%0d got=%b exp=%b", n, bus.issue_valid, s >= 0); end
      if (s >= 0) begin
        checks++;
        if (bus.issue_pc !== mq[s].pc || bus.issue_op !== mq[s].op ||
            bus.issue_datax !== mq[s].dx || bus.issue_datay !== mq[s].dy ||
            bus.issue_tagw !== mq[s].tw || bus.issue_rd !== mq[s].rd) begin
          errors++;
          $display("FAIL rnd_issue_fields cyc=%0d got pc=%h x=%h y=%h exp pc=%h x=%h y=%h",
                   n, bus.issue_pc, bus.issue_datax, bus.issue_datay, mq[s].pc, mq[s].dx, mq[s].dy);
        end
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc_ready_op();
    test_wakeup();
    test_bypass_multi();
    test_age_order();
    test_full();
    test_flush_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rs_alu_pool.md
# rs_alu_pool

Parametrised ALU reservation station for the out-of-order core. It holds up to DEPTH dispatched ALU micro-ops and captures operand values from CDB_CNT result broadcast buses. Each cycle it issues the oldest entry whose operands are both resolved to a single downstream ALU. It sits between the allocator and the ALU executor, and everything is clocked on the rising edge only.

## Interface
- DEPTH, 4: entry count, ≥2.
- CDB_CNT, 3: number of result broadcast buses, ≥1.
- TAG_W, 4: register-tag width; tag value 0 means the operand is resolved (ready).
- XLEN, 32: data and PC width.
- OP_W, 6: micro-op width.
- RA_W, 5: destination architectural register index width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  mispredict flush; empties all entries.
- alloc_valid  in  1  allocator presents an op.
- alloc_ready  out  1  space available.
- alloc_pc  in  XLEN  op PC.
- alloc_op  in  OP_W  micro-op.
- alloc_tagx, alloc_tagy  in  TAG_W  source tags; 0 means the data is valid.
- alloc_datax, alloc_datay  in  XLEN  source data, meaningful when the matching tag is 0.
- alloc_tagw  in  TAG_W  destination tag.
- alloc_rd  in  RA_W  destination register.
- cdb_valid  in  CDB_CNT  per-bus broadcast valid.
- cdb_tag  in  CDB_CNT*TAG_W  packed tags; bus k is at bits [k*TAG_W +: TAG_W].
- cdb_data  in  CDB_CNT*XLEN  packed results.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  ALU accepts.
- issue_pc, issue_op, issue_datax, issue_datay, issue_tagw, issue_rd  out  as alloc  selected entry fields.
- count  out  clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a collapsing queue. Entry 0 is always the oldest. Occupied entries are contiguous in 0..count-1.
- **Allocate:** alloc_valid && alloc_ready writes slot count, or slot count-1 if an issue happens the same cycle.
- **alloc_ready:** equals (count < DEPTH). It gets no credit for a same-cycle issue.
- **Alloc bypass:** an incoming source tag that is nonzero and matches any valid CDB bus in the same cycle is stored with tag 0 and that bus's data.
- **Wakeup:** for every occupied entry and each source, if the tag is nonzero and equals cdb_tag[k] with cdb_valid[k] set, store the data and set the tag to 0.
  - If several buses match, the lowest k wins.
  - A CDB tag of 0 never matches.
- **Ready:** an entry is ready when it is occupied, tagx == 0 and tagy == 0.
- **Select:** the lowest-index ready entry is selected.
  - issue_valid = any ready entry.
  - issue_* outputs are combinational from the selected entry's registered state.
  - A wakeup takes effect in the registered state at the clock edge, so the entry can issue starting the cycle after the broadcast.
- **Issue:** on issue_valid && issue_ready, the selected slot is removed. Entries above it shift down by one, and wakeups are applied to the shifted copies in the same edge.
- **Flush:** flush sets count to 0 and clears all valid bits. It overrides an allocate and an issue in the same cycle, and the flushed op is dropped.
- **Reset:** rst has priority over flush. It sets count=0, clears all entry valids, tags and data, and drives issue_valid=0 and alloc_ready=1.

## Timing
- All state updates on posedge clk.
- **Minimum latency:**
  - Allocate with both tags 0 at edge N → issue_valid from N+1.
  - Waiting entry, CDB match at edge N → issue_valid from N+1.
- **Throughput:** one allocate and one issue per cycle, sustained while not full.
- **Full:** count == DEPTH drives alloc_ready low.
  - An issue that cycle brings count to DEPTH-1, and alloc_ready rises the following cycle.
  - The allocator must hold its op while alloc_ready is low.
- **Empty:** issue_valid=0 and issue_* outputs are don't-care. A simultaneous allocate and flush leaves the station empty.
- **issue_valid without issue_ready:** the entry stays. A younger entry never bypasses an older ready entry.
- **Wrap-around:** none. Slot index is age order, so no pointer wraps.

## Test plan
- **Allocate ready op:** reset, then allocate pc=0x100 with tagx=tagy=0, datax=5, datay=7. Required: issue_valid=1 the next cycle with issue_datax=5, issue_datay=7, and count returns to 0 after the handshake.
- **Wakeup:** allocate tagx=3, tagy=0. Hold for 3 cycles and confirm issue_valid=0. Broadcast cdb_valid[1]=1, tag 3, data 0xDEAD. Required: issue_valid=1 the next cycle with issue_datax=0xDEAD.
- **Same-cycle bypass and multi-match:** allocate tagx=5 while cdb bus 0 and bus 2 both broadcast tag 5, with data 0x11 and 0x22 respectively. Required: the entry becomes ready and issues datax=0x11.
- **Age order and collapse:** fill four entries A–D, all waiting, then wake C and then A. Required: A issues before C even though C woke first; afterwards count=2 with B in slot 0 and D in slot 1.
- **Full boundary:** fill DEPTH=4 and confirm alloc_ready=0. Hold alloc_valid with issue_ready=1 and one ready entry. Required: alloc_ready=1 one cycle after the issue, the held op is accepted, and count=4.
- **Flush and reset:** with count=3, assert flush together with alloc_valid. Required: count=0, issue_valid=0, and the next allocate lands in slot 0. Repeat the same check with rst instead of flush.
